// File: rtl/rs232_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one rs232_tx serializer
// between NUM_REQ byte sources and sequences its tx_en/tx_busy handshake.
`timescale 1ns/1ps

module rs232_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned LOCK_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 lock_active
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;

    // Modulo-NUM_REQ increment; also covers non-power-of-2 requester counts.
    function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] p);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << p;
    endfunction

    // First valid requester scanning upward from rr_ptr with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            tmo_cnt     <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            grant       <= '0;
            lock_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_busy) begin
                        if (lock_active) begin
                            // Only the lock owner may continue its message.
                            if (req_valid[owner]) begin
                                req_ready <= onehot(owner);
                                state     <= GRANT;
                            end else if (LOCK_TIMEOUT != 0 &&
                                         32'(tmo_cnt) + 32'd1 >= LOCK_TIMEOUT) begin
                                lock_active <= 1'b0;
                                tmo_cnt     <= '0;
                                rr_ptr      <= inc_mod(owner);
                            end else if (tmo_cnt != {CNT_W{1'b1}}) begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end else if (win_found) begin
                            owner     <= win_idx;
                            grant     <= onehot(win_idx);
                            req_ready <= onehot(win_idx);
                            state     <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    req_ready   <= '0;
                    tx_data     <= req_data[{owner, 3'b000} +: 8];
                    tx_en       <= 1'b1;
                    lock_active <= ~req_last[owner];
                    tmo_cnt     <= '0;
                    state       <= SETTLE;
                end
                SETTLE: begin
                    // Blanking cycle so the serializer can raise tx_busy.
                    tx_en <= 1'b0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (!lock_active) begin
                            rr_ptr <= inc_mod(owner);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: a 2-requester instance with an 8-cycle
// lock timeout and a 3-requester instance, each driving a simple serializer model.
`timescale 1ns/1ps

module tb_rs232_tx_arbiter;

    logic        clk;
    logic        resetn;

    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        lock_active;

    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_last3;
    logic [2:0]  req_ready3;
    logic [7:0]  tx_data3;
    logic        tx_en3;
    logic        tx_busy3;
    logic [2:0]  grant3;
    logic        lock_active3;

    logic        force_busy;
    int          busy_cnt  = 0;
    int          busy_cnt3 = 0;
    int          tests     = 0;
    int          fails     = 0;
    int          viol      = 0;
    logic [7:0]  log_q[$];
    logic [7:0]  log3_q[$];
    logic [2:0]  glog3_q[$];

    rs232_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(8)) u_dut2 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_en(tx_en),
        .tx_busy(tx_busy), .grant(grant), .lock_active(lock_active)
    );

    rs232_tx_arbiter #(.NUM_REQ(3), .LOCK_TIMEOUT(0)) u_dut3 (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid3), .req_data(req_data3), .req_last(req_last3),
        .req_ready(req_ready3), .tx_data(tx_data3), .tx_en(tx_en3),
        .tx_busy(tx_busy3), .grant(grant3), .lock_active(lock_active3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer models: busy for 4 cycles after each start pulse.
    always @(posedge clk) begin
        if (tx_en) busy_cnt <= 4;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (tx_en3) busy_cnt3 <= 4;
        else if (busy_cnt3 != 0) busy_cnt3 <= busy_cnt3 - 1;
    end
    assign tx_busy  = force_busy | (busy_cnt != 0);
    assign tx_busy3 = (busy_cnt3 != 0);

    always @(negedge clk) begin
        if (tx_en) log_q.push_back(tx_data);
        if (tx_en3) begin
            log3_q.push_back(tx_data3);
            glog3_q.push_back(grant3);
        end
        if ((tx_en && tx_busy) || (tx_en3 && tx_busy3)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int i);
        return (log_q.size() > i) ? 32'(log_q[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] q3get(input int i);
        return (log3_q.size() > i) ? 32'(log3_q[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] g3get(input int i);
        return (glog3_q.size() > i) ? 32'(glog3_q[i]) : 32'hDEAD;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn     = 1'b0;
        req_valid  = '0;
        req_valid3 = '0;
        force_busy = 1'b0;
        repeat (8) @(negedge clk);
        log_q.delete();
        log3_q.delete();
        glog3_q.delete();
        resetn = 1'b1;
    endtask

    task automatic wait_ready(input int idx, input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready[idx]) break;
        end
        check(tag, 32'(req_ready[idx]), 32'd1);
    endtask

    task automatic wait_log(input int n, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (log_q.size() >= n) break;
            @(negedge clk);
        end
        check(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    initial begin
        int cnt;
        int seen;
        resetn     = 1'b0;
        force_busy = 1'b0;
        req_valid  = 2'b11;
        req_data   = 16'h4241;
        req_last   = 2'b11;
        req_valid3 = '0;
        req_data3  = 24'hA2A1A0;
        req_last3  = 3'b111;

        // Reset with both requesters valid and serializer idle.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_lock", 32'(lock_active), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("lat_req_ready", 32'(req_ready), 32'd1);
        check("lat_grant", 32'(grant), 32'd1);
        check("lat_tx_en_early", 32'(tx_en), 32'd0);
        @(negedge clk);
        check("lat_tx_en", 32'(tx_en), 32'd1);
        check("lat_tx_data", 32'(tx_data), 32'h41);
        check("lat_ready_drop", 32'(req_ready), 32'd0);

        // Continuous single-byte messages alternate.
        wait_log(3, "alt_wait");
        check("alt_b0", qget(0), 32'h41);
        check("alt_b1", qget(1), 32'h42);
        check("alt_b2", qget(2), 32'h41);

        // Two-byte locked message from req0 while req1 waits.
        do_reset();
        req_data  = 16'h5548;
        req_last  = 2'b10;
        req_valid = 2'b11;
        wait_ready(0, "hi_r0a");
        @(negedge clk);
        req_data[7:0] = 8'h49;
        req_last[0]   = 1'b1;
        check("hi_lock_mid", 32'(lock_active), 32'd1);
        wait_ready(0, "hi_r0b");
        check("hi_lock_grant", 32'(lock_active), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("hi_unlock", 32'(lock_active), 32'd0);
        wait_ready(1, "hi_r1");
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_log(3, "hi_wait");
        check("hi_b0", qget(0), 32'h48);
        check("hi_b1", qget(1), 32'h49);
        check("hi_b2", qget(2), 32'h55);

        // Lock timeout: req0 sends an unfinished message and goes idle.
        do_reset();
        req_data  = 16'h3130;
        req_last  = 2'b10;
        req_valid = 2'b11;
        wait_ready(0, "to_r0");
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_busy) break;
            @(negedge clk);
        end
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!lock_active) break;
            if (!tx_busy) cnt++;
        end
        check("to_release_cycles", 32'(cnt), 32'd9);
        check("to_grant_hold", 32'(grant), 32'd1);
        @(negedge clk);
        check("to_r1_ready", 32'(req_ready), 32'd2);
        check("to_grant_r1", 32'(grant), 32'd2);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_log(2, "to_wait");
        check("to_b0", qget(0), 32'h30);
        check("to_b1", qget(1), 32'h31);

        // Serializer busy after reset, then asynchronous reset during SETTLE.
        do_reset();
        force_busy = 1'b1;
        req_data   = 16'h6261;
        req_last   = 2'b11;
        req_valid  = 2'b11;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (req_ready != 2'b00) seen++;
        end
        check("busy_no_ready", 32'(seen), 32'd0);
        force_busy = 1'b0;
        wait_ready(0, "busy_r0");
        @(negedge clk);
        check("settle_tx_en", 32'(tx_en), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("async_tx_en", 32'(tx_en), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_ready", 32'(req_ready), 32'd0);
        check("async_tx_data", 32'(tx_data), 32'd0);

        // Three requesters, all valid: order 0,1,2,0.
        do_reset();
        req_valid3 = 3'b111;
        for (int i = 0; i < 400; i++) begin
            if (log3_q.size() >= 4) break;
            @(negedge clk);
        end
        check("rr3_wait", 32'(log3_q.size() >= 4), 32'd1);
        check("rr3_g0", g3get(0), 32'd1);
        check("rr3_g1", g3get(1), 32'd2);
        check("rr3_g2", g3get(2), 32'd4);
        check("rr3_g3", g3get(3), 32'd1);
        check("rr3_d2", q3get(2), 32'hA2);
        check("rr3_d3", q3get(3), 32'hA0);
        req_valid3 = '0;

        repeat (10) @(negedge clk);
        check("tx_en_while_busy", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
